// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind the MySpi byte interface: synchronises the
// SPI byte strobe and chip select into sysclk, decodes bursts and drives the fan map.
module spi_reg_ctrl #(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] DUTY_RESET = 8'hFF
) (
    input  logic        sysclk,
    input  logic        nReset,
    input  logic        iRxReady,
    input  logic [7:0]  iRx,
    input  logic        iSPICS,
    output logic        oTxReady,
    output logic [7:0]  oTx,
    input  logic [15:0] iTach,
    output logic [7:0]  oCtrl,
    output logic [7:0]  oDuty,
    output logic        oBusy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_CTRL    = 3'd1;
    localparam logic [2:0] ADDR_DUTY    = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_TACH_LO = 3'd4;
    localparam logic [2:0] ADDR_TACH_HI = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH = 3'd6;

    function automatic logic [7:0] read_reg(
        input logic [2:0] a,
        input logic [7:0] ctrl,
        input logic [7:0] duty,
        input logic [2:0] status,
        input logic [7:0] tach_lo,
        input logic [7:0] tach_hi,
        input logic [7:0] scratch
    );
        logic [7:0] v;
        case (a)
            ADDR_ID:      v = ID_VALUE;
            ADDR_CTRL:    v = ctrl;
            ADDR_DUTY:    v = duty;
            ADDR_STATUS:  v = {5'd0, status};
            ADDR_TACH_LO: v = tach_lo;
            ADDR_TACH_HI: v = tach_hi;
            ADDR_SCRATCH: v = scratch;
            default:      v = 8'h00;
        endcase
        return v;
    endfunction

    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic       cs_armed_q, cs_armed_d;
    logic       busy_q, busy_d;
    state_t     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] duty_q, duty_d;
    logic [7:0] scratch_q, scratch_d;
    logic [7:0] tach_hi_q, tach_hi_d;
    logic [2:0] status_q, status_d;
    logic [7:0] tx_q, tx_d;
    logic       tx_ready_q, tx_ready_d;
    logic [2:0] status_set_s;
    logic       status_clr_s;
    logic       load_tx_s;
    logic       byte_evt_s, cs_fall_s, cs_rise_s;

    // Edge detectors only see chip-select values that came through the pin, so a
    // CS held low across reset release is not mistaken for the start of a frame.
    assign byte_evt_s = rx_sync_q & ~rx_prev_q;
    assign cs_fall_s  = cs_prev_q & ~cs_sync_q;
    assign cs_rise_s  = ~cs_prev_q & cs_sync_q;

    // Synchroniser chains, edge history and busy flag.
    always_ff @(posedge sysclk or negedge nReset) begin
        if (!nReset) begin
            rx_meta_q  <= 1'b0;
            rx_sync_q  <= 1'b0;
            rx_prev_q  <= 1'b0;
            cs_meta_q  <= 1'b0;
            cs_sync_q  <= 1'b0;
            cs_prev_q  <= 1'b0;
            cs_armed_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= iRxReady;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            cs_meta_q  <= iSPICS;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
            cs_armed_q <= cs_armed_d;
            busy_q     <= busy_d;
        end
    end

    // Busy mirrors synchronised CS once a genuine high level has been seen.
    always_comb begin
        cs_armed_d = cs_armed_q | cs_meta_q;
        busy_d     = cs_armed_q & ~cs_meta_q;
    end

    // State and register-map storage.
    always_ff @(posedge sysclk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 3'd0;
            ctrl_q     <= 8'h00;
            duty_q     <= DUTY_RESET;
            scratch_q  <= 8'h00;
            tach_hi_q  <= 8'h00;
            status_q   <= 3'b000;
            tx_q       <= 8'h00;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ctrl_q     <= ctrl_d;
            duty_q     <= duty_d;
            scratch_q  <= scratch_d;
            tach_hi_q  <= tach_hi_d;
            status_q   <= status_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // Next-state decode; chip-select release overrides any byte in the same cycle.
    always_comb begin
        state_d = state_q;
        if (cs_rise_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = cs_fall_s ? ST_CMD : ST_IDLE;
                ST_CMD:   state_d = byte_evt_s ? (iRx[7] ? ST_WDATA : ST_RDATA) : ST_CMD;
                ST_WDATA: state_d = ST_WDATA;
                ST_RDATA: state_d = ST_RDATA;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Register updates, STATUS bookkeeping and transmit reload per state.
    always_comb begin
        addr_d       = addr_q;
        ctrl_d       = ctrl_q;
        duty_d       = duty_q;
        scratch_d    = scratch_q;
        tach_hi_d    = tach_hi_q;
        tx_ready_d   = tx_ready_q;
        status_set_s = 3'b000;
        status_clr_s = 1'b0;
        load_tx_s    = 1'b0;
        if (cs_rise_s) begin
            tx_ready_d      = 1'b0;
            status_set_s[2] = (state_q == ST_CMD);
        end else begin
            case (state_q)
                ST_IDLE: status_set_s[1] = byte_evt_s;
                ST_CMD: begin
                    if (byte_evt_s) begin
                        addr_d     = iRx[2:0];
                        tx_ready_d = ~iRx[7];
                        load_tx_s  = ~iRx[7];
                    end else begin
                        addr_d = addr_q;
                    end
                end
                ST_WDATA: begin
                    if (byte_evt_s) begin
                        case (addr_q)
                            ADDR_CTRL:    ctrl_d    = iRx;
                            ADDR_DUTY:    duty_d    = iRx;
                            ADDR_SCRATCH: scratch_d = iRx;
                            ADDR_ID, ADDR_STATUS, ADDR_TACH_LO, ADDR_TACH_HI:
                                status_set_s[0] = 1'b1;
                            default:      status_set_s[0] = 1'b0;
                        endcase
                        addr_d = addr_q + 3'd1;
                    end else begin
                        addr_d = addr_q;
                    end
                end
                ST_RDATA: begin
                    // Side effects belong to the byte that just went out on MISO.
                    if (byte_evt_s) begin
                        status_clr_s = (addr_q == ADDR_STATUS);
                        tach_hi_d    = (addr_q == ADDR_TACH_LO) ? iTach[15:8] : tach_hi_q;
                        addr_d       = addr_q + 3'd1;
                        load_tx_s    = 1'b1;
                        tx_ready_d   = 1'b1;
                    end else begin
                        addr_d = addr_q;
                    end
                end
                default: tx_ready_d = 1'b0;
            endcase
        end
        status_d = (status_q & ~{3{status_clr_s}}) | status_set_s;
        tx_d     = load_tx_s ? read_reg(addr_d, ctrl_d, duty_d, status_d, iTach[7:0],
                                        tach_hi_d, scratch_d)
                             : tx_q;
    end

    assign oTxReady = tx_ready_q;
    assign oTx      = tx_q;
    assign oCtrl    = ctrl_q;
    assign oDuty    = duty_q;
    assign oBusy    = busy_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed vector table, timing corner
// sequences and randomized frames against a transaction-level reference model.
module tb_spi_reg_ctrl;
    logic        sysclk = 1'b0;
    logic        nReset;
    logic        iRxReady;
    logic [7:0]  iRx;
    logic        iSPICS;
    logic        oTxReady;
    logic [7:0]  oTx;
    logic [15:0] iTach;
    logic [7:0]  oCtrl;
    logic [7:0]  oDuty;
    logic        oBusy;

    int checks   = 0;
    int failures = 0;

    spi_reg_ctrl dut (
        .sysclk(sysclk), .nReset(nReset), .iRxReady(iRxReady), .iRx(iRx),
        .iSPICS(iSPICS), .oTxReady(oTxReady), .oTx(oTx), .iTach(iTach),
        .oCtrl(oCtrl), .oDuty(oDuty), .oBusy(oBusy)
    );

    always #5 sysclk = ~sysclk;

    localparam logic [1:0] OP_CSL = 2'd0, OP_BYTE = 2'd1, OP_CSH = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        logic [15:0] tach;
        logic        chk_tx;
        logic [7:0]  exp_tx;
        logic        exp_txr;
        logic [7:0]  exp_ctrl;
        logic [7:0]  exp_duty;
    } vec_t;

    vec_t vq[$];
    logic busy_exp;

    function automatic void add(input logic [1:0] op, input logic [7:0] data,
                                input logic [15:0] tach, input logic chk_tx,
                                input logic [7:0] tx, input logic txr,
                                input logic [7:0] ctrl, input logic [7:0] duty);
        vec_t v;
        v.op = op; v.data = data; v.tach = tach; v.chk_tx = chk_tx;
        v.exp_tx = tx; v.exp_txr = txr; v.exp_ctrl = ctrl; v.exp_duty = duty;
        vq.push_back(v);
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_csl();
        iSPICS = 1'b0;
        repeat (6) @(negedge sysclk);
    endtask

    task automatic do_csh();
        iSPICS = 1'b1;
        repeat (6) @(negedge sysclk);
    endtask

    task automatic do_byte(input logic [7:0] b);
        iRx = b;
        iRxReady = 1'b1;
        repeat (4) @(negedge sysclk);
        iRxReady = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    // Transaction-level reference model
    localparam int P_IDLE = 0, P_CMD = 1, P_WR = 2, P_RD = 3;
    logic [7:0] m_ctrl, m_duty, m_scratch, m_shadow, m_tx;
    logic [2:0] m_status;
    logic       m_txr, m_cs_low;
    int         m_phase, m_addr;

    function automatic logic [7:0] m_read(input int a);
        case (a)
            0:       return 8'hA5;
            1:       return m_ctrl;
            2:       return m_duty;
            3:       return {5'd0, m_status};
            4:       return iTach[7:0];
            5:       return m_shadow;
            6:       return m_scratch;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl = 8'h00; m_duty = 8'hFF; m_scratch = 8'h00; m_shadow = 8'h00;
        m_status = 3'b000; m_tx = 8'h00; m_txr = 1'b0; m_cs_low = 1'b0;
        m_phase = P_IDLE; m_addr = 0;
    endtask

    task automatic m_csl();
        m_cs_low = 1'b1;
        m_phase = P_CMD;
    endtask

    task automatic m_csh();
        m_cs_low = 1'b0;
        if (m_phase == P_CMD) m_status[2] = 1'b1;
        m_phase = P_IDLE;
        m_txr = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        case (m_phase)
            P_IDLE: m_status[1] = 1'b1;
            P_CMD: begin
                m_addr = int'(b[2:0]);
                if (b[7]) begin
                    m_phase = P_WR;
                end else begin
                    m_phase = P_RD;
                    m_txr = 1'b1;
                    m_tx = m_read(m_addr);
                end
            end
            P_WR: begin
                case (m_addr)
                    1: m_ctrl = b;
                    2: m_duty = b;
                    6: m_scratch = b;
                    7: ;
                    default: m_status[0] = 1'b1;
                endcase
                m_addr = (m_addr + 1) % 8;
            end
            default: begin
                if (m_addr == 3) m_status = 3'b000;
                if (m_addr == 4) m_shadow = iTach[15:8];
                m_addr = (m_addr + 1) % 8;
                m_tx = m_read(m_addr);
            end
        endcase
    endtask

    task automatic cmp_model(input string tag);
        chk1({tag, "_txr"}, oTxReady, m_txr);
        if (m_txr) chk8({tag, "_tx"}, oTx, m_tx);
        chk8({tag, "_ctrl"}, oCtrl, m_ctrl);
        chk8({tag, "_duty"}, oDuty, m_duty);
        chk1({tag, "_busy"}, oBusy, m_cs_low);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t1;
        logic [15:0] t2;
        logic [7:0]  b;
        int          nb;
        t1 = 16'h1234;
        t2 = 16'hABCD;

        nReset = 1'b0; iSPICS = 1'b1; iRxReady = 1'b0; iRx = 8'h00; iTach = 16'h0000;
        repeat (3) @(negedge sysclk);
        nReset = 1'b1;
        repeat (4) @(negedge sysclk);
        chk1("rst_txr", oTxReady, 1'b0);
        chk8("rst_tx", oTx, 8'h00);
        chk8("rst_ctrl", oCtrl, 8'h00);
        chk8("rst_duty", oDuty, 8'hFF);
        chk1("rst_busy", oBusy, 1'b0);

        // write burst
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF);
        add(OP_BYTE, 8'h81, t1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF);
        add(OP_BYTE, 8'h3C, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'hFF);
        add(OP_BYTE, 8'h40, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h03, t1, 1'b1, 8'h00, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        // read with wrap 6 -> 7 -> 0 -> 1
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h06, t1, 1'b1, 8'h00, 1'b1, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t1, 1'b1, 8'h00, 1'b1, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t1, 1'b1, 8'hA5, 1'b1, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t1, 1'b1, 8'h3C, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        // read-only write, ID check, clear-on-read STATUS
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h80, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'hFF, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t1, 1'b1, 8'hA5, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h03, t1, 1'b1, 8'h01, 1'b1, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t1, 1'b1, 8'h34, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h03, t1, 1'b1, 8'h00, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        // TACH snapshot
        add(OP_CSL, 8'h00, t1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h04, t1, 1'b1, 8'h34, 1'b1, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t1, 1'b1, 8'h12, 1'b1, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h00, t2, 1'b1, 8'h00, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSL, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h05, t2, 1'b1, 8'h12, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        // truncated frame and stray byte
        add(OP_CSL, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h55, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_CSL, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);
        add(OP_BYTE, 8'h03, t2, 1'b1, 8'h06, 1'b1, 8'h3C, 8'h40);
        add(OP_CSH, 8'h00, t2, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h40);

        busy_exp = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            iTach = vq[i].tach;
            case (vq[i].op)
                OP_CSL:  begin do_csl(); busy_exp = 1'b1; end
                OP_CSH:  begin do_csh(); busy_exp = 1'b0; end
                default: do_byte(vq[i].data);
            endcase
            chk1($sformatf("vec%0d_txr", i), oTxReady, vq[i].exp_txr);
            if (vq[i].chk_tx) chk8($sformatf("vec%0d_tx", i), oTx, vq[i].exp_tx);
            chk8($sformatf("vec%0d_ctrl", i), oCtrl, vq[i].exp_ctrl);
            chk8($sformatf("vec%0d_duty", i), oDuty, vq[i].exp_duty);
            chk1($sformatf("vec%0d_busy", i), oBusy, busy_exp);
        end

        // oBusy lags iSPICS by two cycles
        iSPICS = 1'b0;
        @(negedge sysclk);
        chk1("busy_lag1", oBusy, 1'b0);
        @(negedge sysclk);
        chk1("busy_lag2", oBusy, 1'b1);
        repeat (4) @(negedge sysclk);
        // write lands 3-4 cycles after iRxReady rises
        do_byte(8'h81);
        iRx = 8'h77;
        iRxReady = 1'b1;
        @(negedge sysclk);
        chk8("wr_lat_early", oCtrl, 8'h3C);
        repeat (3) @(negedge sysclk);
        chk8("wr_lat_done", oCtrl, 8'h77);
        iRxReady = 1'b0;
        repeat (4) @(negedge sysclk);
        do_csh();
        // oTxReady drops a few cycles after CS rises
        do_csl();
        do_byte(8'h01);
        chk8("txr_seq_tx", oTx, 8'h77);
        iSPICS = 1'b1;
        @(negedge sysclk);
        chk1("txr_hold", oTxReady, 1'b1);
        repeat (2) @(negedge sysclk);
        chk1("txr_drop", oTxReady, 1'b0);
        repeat (4) @(negedge sysclk);
        // async reset mid-frame, CS held low across release
        do_csl();
        do_byte(8'h02);
        chk1("pre_rst_txr", oTxReady, 1'b1);
        #2;
        nReset = 1'b0;
        #1;
        chk1("arst_txr", oTxReady, 1'b0);
        chk8("arst_tx", oTx, 8'h00);
        chk8("arst_ctrl", oCtrl, 8'h00);
        chk8("arst_duty", oDuty, 8'hFF);
        chk1("arst_busy", oBusy, 1'b0);
        @(negedge sysclk);
        nReset = 1'b1;
        repeat (6) @(negedge sysclk);
        do_byte(8'h03);
        chk1("post_rst_idle_txr", oTxReady, 1'b0);
        chk1("post_rst_idle_busy", oBusy, 1'b0);
        do_csh();
        do_csl();
        do_byte(8'h03);
        chk8("post_rst_status", oTx, 8'h02);
        chk1("post_rst_busy", oBusy, 1'b1);
        do_csh();

        // randomized frames against the model
        nReset = 1'b0;
        @(negedge sysclk);
        nReset = 1'b1;
        repeat (4) @(negedge sysclk);
        m_reset();
        cmp_model("rnd_rst");
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = 8'($urandom);
                do_byte(b);
                m_byte(b);
                cmp_model($sformatf("rnd%0d_stray", f));
            end
            do_csl();
            m_csl();
            cmp_model($sformatf("rnd%0d_csl", f));
            nb = $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) begin
                iTach = 16'($urandom);
                b = 8'($urandom);
                do_byte(b);
                m_byte(b);
                cmp_model($sformatf("rnd%0d_b%0d", f, k));
            end
            do_csh();
            m_csh();
            cmp_model($sformatf("rnd%0d_csh", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
